// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: frame parity modes, transmitter
// FSM states, line levels and an elaboration-time parameter sanity check.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   // True when the frame/FIFO parameter set is one the transmitter supports.
   function automatic bit params_ok(input int clk_rate, input int baud_rate,
                                    input int word_width, input int stop_bits,
                                    input int fifo_depth);
      bit ok;
      ok = 1'b1;
      if (baud_rate <= 0 || clk_rate <= 0) ok = 1'b0;
      else if ((clk_rate / baud_rate) < 2) ok = 1'b0;
      if (word_width < 5 || word_width > 9) ok = 1'b0;
      if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
      if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; shared by the UART
// transmit and receive paths.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             push;
   logic             pop;

   // Full/empty come from the registered count only, so a push into a full FIFO
   // is dropped even if a pop happens on the same edge.
   assign push = wr_en && !full;
   assign pop  = rd_en && !empty;

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO: queued words are serialised
// back-to-back as start / data (LSB first) / optional parity / stop frames.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int      CLK_RATE    = 100000000,
   parameter int      BAUD_RATE   = 115200,
   parameter int      WORD_WIDTH  = 8,
   parameter parity_t PARITY_MODE = PARITY_EVEN,
   parameter int      STOP_BITS   = 1,
   parameter int      FIFO_DEPTH  = 4
) (
   input  logic                            clock,
   input  logic                            rst,
   input  logic                            tx_data_valid,
   input  logic [WORD_WIDTH-1:0]           tx_data_in,
   output logic                            tx_ready,
   output logic                            tx_data_out,
   output logic                            tx_busy,
   output logic                            tx_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int BAUD_DIV = CLK_RATE / BAUD_RATE;
   localparam int BAUD_W   = $clog2(BAUD_DIV);
   localparam int BIT_W    = $clog2(WORD_WIDTH + 1);

   if (!params_ok(CLK_RATE, BAUD_RATE, WORD_WIDTH, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
      $error("uart_tx_fifo: unsupported parameter set");
   end

   tx_state_t             state;
   tx_state_t             state_nx;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BAUD_W-1:0]     baud_nx;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_nx;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic [WORD_WIDTH-1:0] shift_nx;
   logic [WORD_WIDTH-1:0] word_reg;
   logic [WORD_WIDTH-1:0] word_nx;
   logic                  line_q;
   logic                  line_nx;

   logic                  fifo_pop;
   logic [WORD_WIDTH-1:0] fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;

   logic                  baud_end;
   logic                  stop_last;
   logic                  parity_bit;

   uart_sync_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (tx_data_valid),
      .wr_data (tx_data_in),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign baud_end   = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
   assign stop_last  = (state == ST_STOP) && baud_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
   // Parity comes from the held copy of the word; the shift register is consumed by then.
   assign parity_bit = (^word_reg) ^ (PARITY_MODE == PARITY_ODD);

   always_comb begin
      state_nx = state;
      fifo_pop = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (baud_end) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (baud_end && bit_cnt == BIT_W'(WORD_WIDTH - 1))
               state_nx = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: begin
            if (baud_end) state_nx = ST_STOP;
         end
         ST_STOP: begin
            if (stop_last) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_nx = ST_START;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift_reg;
      word_nx  = word_reg;
      line_nx  = LINE_IDLE;

      // STOP->START for a queued word is a state change too, so counters restart.
      if (state_nx != state) begin
         baud_nx = '0;
         bit_nx  = '0;
      end else if (baud_end) begin
         baud_nx = '0;
         if (state == ST_DATA || state == ST_STOP) bit_nx = bit_cnt + 1'b1;
      end else if (state != ST_IDLE) begin
         baud_nx = baud_cnt + 1'b1;
      end

      if (fifo_pop) begin
         shift_nx = fifo_head;
         word_nx  = fifo_head;
      end else if (state == ST_DATA && baud_end) begin
         shift_nx = shift_reg >> 1;
      end

      case (state_nx)
         ST_IDLE:   line_nx = LINE_IDLE;
         ST_START:  line_nx = LINE_START;
         ST_DATA:   line_nx = shift_nx[0];
         ST_PARITY: line_nx = parity_bit;
         ST_STOP:   line_nx = LINE_STOP;
         default:   line_nx = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= ST_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         word_reg  <= '0;
         line_q    <= LINE_IDLE;
      end else begin
         state     <= state_nx;
         baud_cnt  <= baud_nx;
         bit_cnt   <= bit_nx;
         shift_reg <= shift_nx;
         word_reg  <= word_nx;
         line_q    <= line_nx;
      end
   end

   assign tx_data_out = line_q;
   assign tx_busy     = (state != ST_IDLE);
   assign tx_done     = stop_last;
   assign tx_ready    = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three frame formats at BAUD_DIV=10, expected
// frames queued at push time and checked slot by slot by a line monitor.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] din   = 8'h00;
   int         sel   = 0;

   logic vld_a, vld_b, vld_c;
   logic ready_a, line_a, busy_a, done_a;
   logic ready_b, line_b, busy_b, done_b;
   logic ready_c, line_c, busy_c, done_c;
   logic [2:0] cnt_a, cnt_b, cnt_c;

   logic       m_line, m_busy, m_done, m_ready;
   logic [2:0] m_cnt;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      bit          b2b;
   } frame_t;

   frame_t exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   always #5 clock = ~clock;

   assign vld_a = valid && (sel == 0);
   assign vld_b = valid && (sel == 1);
   assign vld_c = valid && (sel == 2);

   uart_tx_fifo #(.CLK_RATE(1000), .BAUD_RATE(100), .WORD_WIDTH(8), .PARITY_MODE(PARITY_EVEN),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .clock(clock), .rst(rst), .tx_data_valid(vld_a), .tx_data_in(din),
      .tx_ready(ready_a), .tx_data_out(line_a), .tx_busy(busy_a), .tx_done(done_a),
      .fifo_count(cnt_a));

   uart_tx_fifo #(.CLK_RATE(1000), .BAUD_RATE(100), .WORD_WIDTH(7), .PARITY_MODE(PARITY_NONE),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
      .clock(clock), .rst(rst), .tx_data_valid(vld_b), .tx_data_in(din[6:0]),
      .tx_ready(ready_b), .tx_data_out(line_b), .tx_busy(busy_b), .tx_done(done_b),
      .fifo_count(cnt_b));

   uart_tx_fifo #(.CLK_RATE(1000), .BAUD_RATE(100), .WORD_WIDTH(8), .PARITY_MODE(PARITY_ODD),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
      .clock(clock), .rst(rst), .tx_data_valid(vld_c), .tx_data_in(din),
      .tx_ready(ready_c), .tx_data_out(line_c), .tx_busy(busy_c), .tx_done(done_c),
      .fifo_count(cnt_c));

   always_comb begin
      case (sel)
         1:       begin m_line = line_b; m_busy = busy_b; m_done = done_b; m_ready = ready_b; m_cnt = cnt_b; end
         2:       begin m_line = line_c; m_busy = busy_c; m_done = done_c; m_ready = ready_c; m_cnt = cnt_c; end
         default: begin m_line = line_a; m_busy = busy_a; m_done = done_a; m_ready = ready_a; m_cnt = cnt_a; end
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // bits: slot i of the frame is bits[i] (start in bit 0, stop bits on top).
   task automatic push_word(input logic [7:0] w, input logic [15:0] bits, input int nbits,
                            input bit b2b, input bit accepted);
      frame_t f;
      valid = 1'b1;
      din   = w;
      if (accepted) begin
         f.bits = bits; f.nbits = nbits; f.b2b = b2b;
         exp_q.push_back(f);
      end
      @(negedge clock);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((m_busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_busy_low"}, m_busy, 0);
      check({name, "_count_zero"}, m_cnt, 0);
      repeat (30) @(negedge clock);
   endtask

   // Line monitor: on each falling start edge pop one expected frame and check it.
   initial begin : monitor
      int     idle_cnt;
      frame_t e;
      bit     aborted, bad_line, bad_done, bad_busy;
      idle_cnt = 0;
      forever begin
         @(negedge clock);
         if (rst || m_line === 1'b1) begin
            idle_cnt++;
            continue;
         end
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            idle_cnt = 0;
            continue;
         end
         e = exp_q.pop_front();
         if (e.b2b) check("gap_before_frame", idle_cnt, 0);
         aborted = 1'b0;
         for (int s = 0; s < e.nbits && !aborted; s++) begin
            bad_line = 1'b0; bad_done = 1'b0; bad_busy = 1'b0;
            for (int c = 0; c < 10; c++) begin
               if (c != 0 || s != 0) @(negedge clock);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (m_line !== e.bits[s]) bad_line = 1'b1;
               if (m_done !== ((s == e.nbits - 1) && (c == 9))) bad_done = 1'b1;
               if (m_busy !== 1'b1) bad_busy = 1'b1;
            end
            if (!aborted) begin
               check($sformatf("line_slot%0d_err", s), bad_line, 0);
               check($sformatf("done_slot%0d_err", s), bad_done, 0);
               check($sformatf("busy_slot%0d_err", s), bad_busy, 0);
            end
         end
         idle_cnt = 0;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int busy_cyc, done_cyc, n, cnt_peak;
      logic [2:0] cnt_exp [6];
      cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_line", line_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_count", cnt_a, 0);
      check("rst_ready", ready_a, 1);
      rst = 1'b0;
      repeat (3) @(negedge clock);

      // Single word 0xA5, 8E1: line 0,1,0,1,0,0,1,0,1,0,1
      sel = 0;
      push_word(8'hA5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 1'b1);
      valid = 1'b0;
      busy_cyc = 0; done_cyc = 0;
      repeat (300) begin
         if (m_busy === 1'b1) busy_cyc++;
         if (m_done === 1'b1) done_cyc++;
         @(negedge clock);
      end
      check("single_busy_cycles", busy_cyc, 110);
      check("single_done_pulses", done_cyc, 1);
      wait_idle("single", 300);

      // Back-to-back 0x00, 0xFF, 0x3C, even parity 0,0,0
      push_word(8'h00, {5'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 1'b0, 1'b1);
      push_word(8'hFF, {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 1'b1, 1'b1);
      push_word(8'h3C, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1, 1'b1);
      valid = 1'b0;
      wait_idle("b2b", 600);

      // FIFO full: words 1..6 on consecutive cycles, word 6 dropped
      cnt_peak = 0;
      for (int i = 1; i <= 6; i++) begin
         case (i)
            1: push_word(8'd1, {5'b0, 1'b1, 1'b1, 8'd1, 1'b0}, 11, 1'b0, 1'b1);
            2: push_word(8'd2, {5'b0, 1'b1, 1'b1, 8'd2, 1'b0}, 11, 1'b1, 1'b1);
            3: push_word(8'd3, {5'b0, 1'b1, 1'b0, 8'd3, 1'b0}, 11, 1'b1, 1'b1);
            4: push_word(8'd4, {5'b0, 1'b1, 1'b1, 8'd4, 1'b0}, 11, 1'b1, 1'b1);
            5: push_word(8'd5, {5'b0, 1'b1, 1'b0, 8'd5, 1'b0}, 11, 1'b1, 1'b1);
            default: push_word(8'd6, 16'h0, 11, 1'b0, 1'b0);
         endcase
         check($sformatf("full_ready_after_push%0d", i), m_ready, (i < 5) ? 1 : 0);
         check($sformatf("full_count_after_push%0d", i), m_cnt, cnt_exp[i-1]);
         if (int'(m_cnt) > cnt_peak) cnt_peak = int'(m_cnt);
      end
      valid = 1'b0;
      n = 0;
      while (m_done !== 1'b1 && n < 200) begin
         if (m_ready !== 1'b0) check("full_ready_held_low", m_ready, 0);
         if (int'(m_cnt) > cnt_peak) cnt_peak = int'(m_cnt);
         @(negedge clock);
         n++;
      end
      check("full_first_done_seen", m_done, 1);
      check("full_ready_on_last_stop", m_ready, 0);
      check("full_count_on_last_stop", m_cnt, 4);
      @(negedge clock);
      check("full_ready_after_pop", m_ready, 1);
      check("full_count_after_pop", m_cnt, 3);
      check("full_count_peak", cnt_peak, 4);
      wait_idle("full", 800);

      // 7N2, 0x55: line 0,1,0,1,0,1,0,1,1,1 over 100 cycles
      sel = 1;
      repeat (2) @(negedge clock);
      push_word(8'h55, {6'b0, 2'b11, 7'h55, 1'b0}, 10, 1'b0, 1'b1);
      valid = 1'b0;
      wait_idle("fmt7n2", 300);

      // 8O1: 0x01 -> parity 0, 0x03 -> parity 1
      sel = 2;
      repeat (2) @(negedge clock);
      push_word(8'h01, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 1'b0, 1'b1);
      valid = 1'b0;
      wait_idle("odd01", 300);
      push_word(8'h03, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1'b0, 1'b1);
      valid = 1'b0;
      wait_idle("odd03", 300);

      // Reset during data bit 3 with two words queued
      sel = 0;
      repeat (2) @(negedge clock);
      push_word(8'h11, {5'b0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, 1'b0, 1'b1);
      push_word(8'h22, {5'b0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, 1'b1, 1'b1);
      push_word(8'h33, {5'b0, 1'b1, 1'b0, 8'h33, 1'b0}, 11, 1'b1, 1'b1);
      valid = 1'b0;
      n = 0;
      while (m_line !== 1'b0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("rstmid_frame_started", m_line, 0);
      repeat (44) @(negedge clock);
      check("rstmid_queued", m_cnt, 2);
      rst = 1'b1;
      @(negedge clock);
      check("rstmid_line", m_line, 1);
      check("rstmid_count", m_cnt, 0);
      check("rstmid_busy", m_busy, 0);
      check("rstmid_done", m_done, 0);
      check("rstmid_ready", m_ready, 1);
      exp_q.delete();
      @(negedge clock);
      rst = 1'b0;
      done_cyc = 0; busy_cyc = 0;
      repeat (150) begin
         @(negedge clock);
         if (m_done === 1'b1) done_cyc++;
         if (m_busy !== 1'b0) busy_cyc++;
      end
      check("rstmid_no_done", done_cyc, 0);
      check("rstmid_stays_idle", busy_cyc, 0);
      push_word(8'h81, {5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11, 1'b0, 1'b1);
      valid = 1'b0;
      wait_idle("after_rst", 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
